// File: rtl/pe_array_drain.sv
// pe_array_drain: output-side collector for the PE_array systolic array.
//
// The array emits column j of each result row j cycles after column 0.
// Each column is delayed by (NUM2-1-j) EN-qualified register stages so that
// every column of a row lines up. A small FSM decides which aligned cycles
// carry real rows. Those rows go into a DEPTH-entry FIFO that drains
// downstream through a valid/ready handshake.
//
// Optional build macro: DRAIN_RELU_EN. When it is defined, each column is
// treated as a signed SUM_W value and clamped to 0 at the FIFO write port.
//
// Ports:
//   CLK, RESET      clock (rising edge), asynchronous active-low reset
//   EN              capture-side enable, shared with PE_array. Low freezes
//                   the FSM, the counters and the deskew lines.
//   START           one-cycle pulse that begins a tile
//   NUM_ROWS        rows in the tile (0 = empty tile)
//   ARRAY_DLY       EN cycles from START until column 0 of row 0 appears
//   in_sum_bottom   skewed column sums; column j at [j*SUM_W +: SUM_W]
//   row_data/row_valid/row_ready/row_last
//                   downstream row handshake; row_last marks the final row
//   busy            FSM is not idle
//   done            one-cycle pulse when capture of a tile completes
//   overflow        sticky; a row was dropped on a full FIFO.
//                   Cleared by the next accepted START.
module pe_array_drain #(
   parameter int NUM2  = 2,
   parameter int SUM_W = 16,
   parameter int DEPTH = 4
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  EN,
   input  logic                  START,
   input  logic [7:0]            NUM_ROWS,
   input  logic [7:0]            ARRAY_DLY,
   input  logic [NUM2*SUM_W-1:0] in_sum_bottom,
   output logic [NUM2*SUM_W-1:0] row_data,
   output logic                  row_valid,
   input  logic                  row_ready,
   output logic                  row_last,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int DW = NUM2 * SUM_W;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE} state_t;

   state_t        state_q, state_d;
   logic [15:0]   wait_q, wait_d;
   logic [7:0]    rows_q, rows_d;
   logic [7:0]    rcnt_q, rcnt_d;
   logic          done_q, done_d;
   logic          ovf_q;
   logic          ovf_clr;
   logic          push, push_last, push_ok, pop, full;
   logic [15:0]   wait_load;

   logic [NUM2-1:0][SUM_W-1:0] aligned;
   logic [NUM2-1:0][SUM_W-1:0] wr_row;

   logic [DW:0]   mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q;

   // ---------------- deskew ----------------
   for (genvar j = 0; j < NUM2; j++) begin : g_col
      localparam int ST = NUM2 - 1 - j;
      if (ST == 0) begin : g_pass
         assign aligned[j] = in_sum_bottom[j*SUM_W +: SUM_W];
      end else begin : g_dly
         logic [ST-1:0][SUM_W-1:0] dly_q;
         always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
               dly_q <= '0;
            end else if (EN) begin
               dly_q[0] <= in_sum_bottom[j*SUM_W +: SUM_W];
               for (int s = 1; s < ST; s++) dly_q[s] <= dly_q[s-1];
            end
         end
         assign aligned[j] = dly_q[ST-1];
      end
   end

   always_comb begin
      wr_row = '0;
      for (int j = 0; j < NUM2; j++) begin
`ifdef DRAIN_RELU_EN
         wr_row[j] = aligned[j][SUM_W-1] ? '0 : aligned[j];
`else
         wr_row[j] = aligned[j];
`endif
      end
   end

   // ---------------- FSM ----------------
   // The first aligned row is valid ARRAY_DLY+NUM2-1 EN-cycles after START.
   // The START cycle itself counts as the first of those cycles. When the
   // total is 0 (NUM2=1, ARRAY_DLY=0), the FSM treats it as 1.
   assign wait_load = 16'(ARRAY_DLY) + 16'(NUM2 - 1);

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      rows_d    = rows_q;
      rcnt_d    = rcnt_q;
      done_d    = 1'b0;
      ovf_clr   = 1'b0;
      push      = 1'b0;
      push_last = 1'b0;
      if (EN) begin
         case (state_q)
            S_IDLE: begin
               if (START) begin
                  rows_d  = NUM_ROWS;
                  rcnt_d  = '0;
                  ovf_clr = 1'b1;
                  if (NUM_ROWS == 8'd0) begin
                     done_d = 1'b1;
                  end else if (wait_load <= 16'd1) begin
                     state_d = S_CAPTURE;
                  end else begin
                     state_d = S_WAIT;
                     wait_d  = wait_load - 16'd1;
                  end
               end
            end
            S_WAIT: begin
               wait_d = wait_q - 16'd1;
               if (wait_q == 16'd1) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
               push      = 1'b1;
               push_last = (rcnt_q == rows_q - 8'd1);
               rcnt_d    = rcnt_q + 8'd1;
               if (push_last) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         rows_q  <= '0;
         rcnt_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         rows_q  <= rows_d;
         rcnt_q  <= rcnt_d;
         done_q  <= done_d;
      end
   end

   // ---------------- FIFO ----------------
   // The array cannot be stalled. A push into a full FIFO succeeds only when
   // a pop frees a slot in the same cycle. Otherwise the row is dropped and
   // overflow is flagged.
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign pop     = row_valid && row_ready;
   assign push_ok = push && (!full || pop);

   always_ff @(posedge CLK) begin
      if (push_ok) mem_q[wptr_q] <= {push_last, wr_row};
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + AW'(1);
         if (pop)     rptr_q <= rptr_q + AW'(1);
         case ({push_ok, pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
         if (ovf_clr)                     ovf_q <= 1'b0;
         else if (push && full && !pop)   ovf_q <= 1'b1;
      end
   end

   // The storage has no reset, so the head entry is gated until a row is
   // present. This keeps the outputs at zero after reset.
   assign row_valid = (cnt_q != '0);
   assign row_data  = row_valid ? mem_q[rptr_q][DW-1:0] : '0;
   assign row_last  = row_valid ? mem_q[rptr_q][DW]     : 1'b0;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_pe_array_drain.sv
// Bench for pe_array_drain (NUM2=2, SUM_W=16, DEPTH=4).
// Stimulus presents skewed column data. Expected rows go to a queue and are
// popped when the DUT hands a row downstream.
module tb_pe_array_drain;
   localparam int NUM2  = 2;
   localparam int SUM_W = 16;
   localparam int DEPTH = 4;
   localparam int DW    = NUM2 * SUM_W;

   logic          CLK = 1'b0;
   logic          RESET = 1'b0;
   logic          EN = 1'b0;
   logic          START = 1'b0;
   logic [7:0]    NUM_ROWS = '0;
   logic [7:0]    ARRAY_DLY = '0;
   logic [DW-1:0] in_sum_bottom = '0;
   logic          row_ready = 1'b0;
   logic [DW-1:0] row_data;
   logic          row_valid, row_last, busy, done, overflow;

   pe_array_drain #(.NUM2(NUM2), .SUM_W(SUM_W), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RESET(RESET), .EN(EN), .START(START),
      .NUM_ROWS(NUM_ROWS), .ARRAY_DLY(ARRAY_DLY), .in_sum_bottom(in_sum_bottom),
      .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
      .row_last(row_last), .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 CLK = ~CLK;

   int checks = 0, errors = 0;
   int done_cnt = 0, pop_cnt = 0, cyc_cnt = 0, done_cyc = 0;
   logic [DW:0]      sb [$];
   logic [DW:0]      exp_v;
   logic [SUM_W-1:0] coldat [NUM2][16];

   always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

   // Row scoreboard and done tracking, sampled on the falling edge.
   always @(negedge CLK) begin
      if (RESET === 1'b1 && row_valid === 1'b1 && row_ready === 1'b1) begin
         pop_cnt++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL row_unexpected got last=%0b data=%h, none expected", row_last, row_data);
         end else begin
            exp_v = sb.pop_front();
            if ({row_last, row_data} !== exp_v)
               begin errors++; $display("FAIL row got %h expected %h", {row_last, row_data}, exp_v); end
         end
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc_cnt; end
   end

   function automatic logic [SUM_W-1:0] model_col(input logic [SUM_W-1:0] v);
`ifdef DRAIN_RELU_EN
      return v[SUM_W-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   task automatic tick(input int n);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   // Drives one tile. Column j of row r is presented at EN-cycle k = dly+r+j,
   // where k=0 is the START cycle. Slots outside the tile carry random junk.
   // keep = number of leading rows expected to survive into the FIFO.
   // gap_at/gap_len = drop EN for gap_len cycles at k==gap_at.
   // restart_at = extra START (NUM_ROWS=0) at that k.
   // abort_at = return early at that k.
   task automatic run_tile(input int rows, input int dly, input int keep,
                           input int gap_at, input int gap_len,
                           input int restart_at, input int abort_at,
                           output int t0);
      int k, gl, kend, r;
      logic [DW:0]   e;
      logic [DW-1:0] bus;
      k = 0; gl = gap_len;
      for (int rr = 0; rr < keep; rr++) begin
         e = '0;
         e[DW] = (rr == rows - 1);
         for (int j = 0; j < NUM2; j++) e[j*SUM_W +: SUM_W] = model_col(coldat[j][rr]);
         sb.push_back(e);
      end
      kend = dly + NUM2 - 1 + rows + 2;
      t0 = cyc_cnt;
      NUM_ROWS = 8'(rows); ARRAY_DLY = 8'(dly);
      while (k < kend) begin
         if (k == abort_at) begin START = 1'b0; return; end
         EN    = !(k == gap_at && gl > 0);
         START = (k == 0) || (k == restart_at && EN);
         if (k == restart_at) NUM_ROWS = 8'd0;
         for (int j = 0; j < NUM2; j++) begin
            r = k - dly - j;
            bus[j*SUM_W +: SUM_W] = (r >= 0 && r < rows) ? coldat[j][r] : SUM_W'($urandom);
         end
         in_sum_bottom = bus;
         tick(1);
         if (EN) k++; else gl--;
      end
      START = 1'b0; EN = 1'b1;
   endtask

   task automatic test_reset();
      tick(2);
      checks++;
      if ({row_valid, row_data, row_last, busy, done, overflow} !== '0)
         begin errors++; $display("FAIL reset_outputs got v=%0b d=%h l=%0b b=%0b dn=%0b o=%0b want all 0",
                                  row_valid, row_data, row_last, busy, done, overflow); end
      RESET = 1'b1; EN = 1'b1; row_ready = 1'b1;
      tick(2);
   endtask

   task automatic test_deskew();
      int t0, d0, p0;
      coldat[0][0] = 16'd11; coldat[0][1] = 16'd12;
      coldat[1][0] = 16'd21; coldat[1][1] = 16'd22;
      d0 = done_cnt; p0 = pop_cnt;
      run_tile(2, 3, 2, -1, 0, -1, -1, t0);
      tick(3);
      checks++; if (pop_cnt - p0 != 2) begin errors++; $display("FAIL deskew_rows got %0d want 2", pop_cnt - p0); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL deskew_done got %0d want 1", done_cnt - d0); end
      checks++; if (done_cyc - t0 != 6) begin errors++; $display("FAIL deskew_done_time got %0d want 6", done_cyc - t0); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL deskew_ovf got %0b want 0", overflow); end
   endtask

   task automatic test_overflow();
      int t0, d0, p0;
      for (int r = 0; r < 6; r++) begin
         coldat[0][r] = 16'(100 + r); coldat[1][r] = 16'(200 + r);
      end
      row_ready = 1'b0;
      d0 = done_cnt; p0 = pop_cnt;
      run_tile(6, 2, 4, -1, 0, -1, -1, t0);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow); end
      checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %0b want 1", row_valid); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ovf_done got %0d want 1", done_cnt - d0); end
      row_ready = 1'b1;
      tick(8);
      checks++; if (pop_cnt - p0 != 4) begin errors++; $display("FAIL ovf_drained got %0d want 4", pop_cnt - p0); end
      checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0b want 0", row_valid); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
   endtask

   task automatic test_en_freeze();
      int t0, d0, p0;
      for (int r = 0; r < 3; r++) begin
         coldat[0][r] = 16'(300 + r); coldat[1][r] = 16'(400 + r);
      end
      d0 = done_cnt; p0 = pop_cnt;
      // Capture pushes at k=3,4,5; EN drops for 2 cycles at k=4.
      run_tile(3, 2, 3, 4, 2, -1, -1, t0);
      tick(3);
      checks++; if (pop_cnt - p0 != 3) begin errors++; $display("FAIL freeze_rows got %0d want 3", pop_cnt - p0); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL freeze_done got %0d want 1", done_cnt - d0); end
      checks++; if (done_cyc - t0 != 8) begin errors++; $display("FAIL freeze_done_time got %0d want 8", done_cyc - t0); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL freeze_ovf_clr got %0b want 0", overflow); end
   endtask

   task automatic test_empty_and_busy_start();
      int t0, d0, p0;
      d0 = done_cnt; p0 = pop_cnt;
      run_tile(0, 2, 0, -1, 0, -1, -1, t0);
      tick(2);
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL empty_done got %0d want 1", done_cnt - d0); end
      checks++; if (done_cyc - t0 != 1) begin errors++; $display("FAIL empty_done_time got %0d want 1", done_cyc - t0); end
      checks++; if (pop_cnt != p0) begin errors++; $display("FAIL empty_rows got %0d want 0", pop_cnt - p0); end
      coldat[0][0] = 16'h0A0A; coldat[1][0] = 16'h0B0B;
      d0 = done_cnt; p0 = pop_cnt;
      run_tile(1, 5, 1, -1, 0, 2, -1, t0);
      tick(3);
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_start_done got %0d want 1", done_cnt - d0); end
      checks++; if (done_cyc - t0 != 7) begin errors++; $display("FAIL busy_start_time got %0d want 7", done_cyc - t0); end
      checks++; if (pop_cnt - p0 != 1) begin errors++; $display("FAIL busy_start_rows got %0d want 1", pop_cnt - p0); end
   endtask

   task automatic test_back_to_back();
      int t0, d0, p0;
      for (int r = 0; r < 3; r++) begin
         coldat[0][r] = 16'(16'h1000 + r); coldat[1][r] = 16'(16'h2000 + r);
      end
      d0 = done_cnt; p0 = pop_cnt;
      run_tile(2, 0, 2, -1, 0, -1, -1, t0);  // ARRAY_DLY=0: no WAIT cycles
      checks++; if (done_cyc - t0 != 3) begin errors++; $display("FAIL b2b_dly0_time got %0d want 3", done_cyc - t0); end
      run_tile(3, 1, 3, -1, 0, -1, -1, t0);
      tick(3);
      checks++; if (pop_cnt - p0 != 5) begin errors++; $display("FAIL b2b_rows got %0d want 5", pop_cnt - p0); end
      checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done got %0d want 2", done_cnt - d0); end
   endtask

   task automatic test_async_reset();
      int t0, d0;
      for (int r = 0; r < 6; r++) begin coldat[0][r] = 16'(r); coldat[1][r] = 16'(r + 50); end
      row_ready = 1'b0;
      // Pushes at k=2..7. At k=7 the FIFO is full, one row has been dropped,
      // and the FSM is still capturing.
      run_tile(6, 1, 0, -1, 0, -1, 7, t0);
      checks++;
      if ({row_valid, busy, overflow} !== 3'b111)
         begin errors++; $display("FAIL pre_reset got v=%0b b=%0b o=%0b want 111", row_valid, busy, overflow); end
      RESET = 1'b0;
      #1;
      checks++;
      if ({row_valid, busy, overflow, row_data} !== '0)
         begin errors++; $display("FAIL async_reset got v=%0b b=%0b o=%0b d=%h want 0", row_valid, busy, overflow, row_data); end
      d0 = done_cnt;
      tick(2);
      RESET = 1'b1; EN = 1'b1; row_ready = 1'b1;
      tick(4);
      checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %0b want 0", row_valid); end
      checks++; if (done_cnt != d0) begin errors++; $display("FAIL post_reset_done got %0d want 0", done_cnt - d0); end
   endtask

   task automatic test_relu();
      int t0, p0;
      coldat[0][0] = 16'hFFF6; coldat[1][0] = 16'd5;
      p0 = pop_cnt;
      run_tile(1, 1, 1, -1, 0, -1, -1, t0);
      tick(3);
      checks++; if (pop_cnt - p0 != 1) begin errors++; $display("FAIL relu_rows got %0d want 1", pop_cnt - p0); end
   endtask

   initial begin
      test_reset();
      test_deskew();
      test_overflow();
      test_en_freeze();
      test_empty_and_busy_start();
      test_back_to_back();
      test_async_reset();
      test_relu();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

endmodule

// File: doc/pe_array_drain.md
Name: pe_array_drain

Overview:
- Output-side collector for the PE_array systolic array. Sits below the array on the out_sum_final bus.
- The array emits partial sums skewed by column: column j lags column 0 by j cycles. This block de-skews the columns into aligned row vectors.
- Aligned rows are buffered in a small FIFO and handed downstream with a valid/ready handshake, with tile framing (last-row flag, done pulse).

Parameters:
- NUM2, 2, number of array columns (matches PE_array num2).
- SUM_W, 16, width of one column partial sum.
- DEPTH, 4, output FIFO depth in rows (power of 2, >=2).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- EN  in  1  same enable that drives PE_array; low freezes capture side.
- START  in  1  one-cycle pulse; begins capture of one result tile.
- NUM_ROWS  in  8  rows in the tile (M); 0 = empty tile.
- ARRAY_DLY  in  8  cycles from START to column-0 row-0 valid on in_sum_bottom.
- in_sum_bottom  in  NUM2*SUM_W  PE_array out_sum_final; column j at bits [j*SUM_W +: SUM_W].
- row_data  out  NUM2*SUM_W  aligned row, same column packing.
- row_valid  out  1  row_data valid.
- row_ready  in  1  downstream accepts.
- row_last  out  1  qualifies row_valid; final row of tile.
- busy  out  1  FSM not IDLE.
- done  out  1  one-cycle pulse when capture of tile completes.
- overflow  out  1  sticky; a row was dropped because FIFO was full.

Behaviour:
- Reset (RESET=0, async): FSM=IDLE, counters 0, FIFO empty, delay lines 0. All outputs 0.
- Timing contract: T0 = START cycle + ARRAY_DLY. Column j, row r is present on in_sum_bottom at cycle T0+r+j, counted in EN-high cycles.
- Deskew: column j passes through (NUM2-1-j) register stages. All columns of row r align at T0+r+NUM2-1.
- FSM states:
  - IDLE: on START&&EN, latch NUM_ROWS and ARRAY_DLY, clear overflow. If NUM_ROWS==0, pulse done next cycle and stay in IDLE. Otherwise go to WAIT.
  - WAIT: count ARRAY_DLY+NUM2-1 cycles, then go to CAPTURE.
  - CAPTURE: push one aligned row per cycle for NUM_ROWS cycles. Tag the final row last=1. After the final push, pulse done and return to IDLE.
- START while busy is ignored.
- EN=0 holds FSM, counters and delay lines, and no push occurs. The FIFO pop side stays active regardless of EN.
- FIFO:
  - Entry = {last, row}. Pop on row_valid&&row_ready.
  - Read latency: a pushed row appears on row_valid the cycle after push.
  - Push and pop in the same cycle when full: the pop frees the slot and the push succeeds.
  - Push when full with no pop: row dropped, overflow set. The array cannot stall, so there is no backpressure to it.
  - Pointers wrap modulo DEPTH; a separate count distinguishes full from empty.
- row_data/row_last hold stable while row_valid&&!row_ready.
- Mid-operation reset: everything returns to reset values and partial tile data is discarded.
- No arithmetic on data other than the optional clamp; widths pass through unchanged.

Optional Feature:
- Macro DRAIN_RELU_EN.
- Defined: each column value is treated as signed SUM_W and clamped to 0 if negative at the FIFO write port (ReLU on output). Timing is unchanged.
- Undefined: values pass through bit-exact.

Test Plan:
- Basic deskew: NUM2=2, ARRAY_DLY=3, NUM_ROWS=2. Drive col0=11 at T0 and 12 at T0+1; col1=21 at T0+1 and 22 at T0+2; row_ready=1.
  -> Rows {c1=21,c0=11} then {22,12}; second row has row_last=1; done pulses once; overflow=0.
- Backpressure overflow: DEPTH=4, NUM_ROWS=6, row_ready=0 throughout.
  -> First 4 rows retained, rows 5-6 dropped, overflow=1. Raise row_ready -> exactly 4 rows drain, in order; none flagged last.
- EN freeze: deassert EN for 2 cycles during CAPTURE, skew data held by the stimulus.
  -> No duplicated or missing rows; done is delayed by exactly 2 cycles.
- Empty tile and start-while-busy: START with NUM_ROWS=0 -> done pulse, no row_valid. A second START during WAIT -> ignored; only one done.
- Async reset mid-CAPTURE with 2 rows queued: RESET low between clock edges -> row_valid, busy and overflow drop immediately; FIFO empty after release.
- DRAIN_RELU_EN defined: col0=16'hFFF6 (-10), col1=5 -> row {5,0}. With the macro undefined -> {5,16'hFFF6}.
